md_sequencer: RTL and testbench

- Sequences the iterative multiply/divide resource behind the EX stage and owns the architectural HI/LO registers.
- Accepts MDFunc/MDSign-encoded operations from EX and runs MULT/DIV over 33 cycles.
- Raises a stall request to the stall-detect logic whenever a later instruction needs the unit or HI/LO before the result is ready.
- Handles MTHI/MTLO in a single cycle and aborts in-flight work on pipeline flush.

---
 rtl/md_pkg.sv | 27 ++
 rtl/md_iter_core.sv | 56 +++++
 rtl/md_sequencer.sv | 151 +++++++++++++++
 tb/tb_md_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencer and its iteration core.
// MDFunc encodings, FSM states and the fixed operation latency live here.
package md_pkg;

   localparam int MD_WIDTH   = 32;
   localparam int MD_LATENCY = MD_WIDTH + 1;

   typedef enum logic [2:0] {
      NOP  = 3'd0,
      MULT = 3'd1,
      DIV  = 3'd2,
      MTHI = 3'd3,
      MTLO = 3'd4
   } md_func_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2
   } md_state_e;

   // Encodings 5-7 behave as NOP, so only 1..4 count as using the unit.
   function automatic logic md_func_live(input logic [2:0] f);
      return (f >= 3'd1) && (f <= 3'd4);
   endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide on unsigned magnitudes.
// One iteration per step; result is {hi, lo} = product, or {remainder, quotient}.
module md_iter_core
   import md_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [WIDTH-1:0]   b_mag,
   output logic [2*WIDTH-1:0] result
);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH:0]   div_shift;
   logic [WIDTH:0]     div_hi;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = {acc, 1'b0};
      div_hi    = div_shift[2*WIDTH:WIDTH];
      div_ge    = div_hi >= {1'b0, opnd};
      // Partial remainder stays below 2*divisor, so the difference fits in WIDTH bits.
      div_diff  = div_hi[WIDTH-1:0] - opnd;
      if (is_div) begin
         acc_nxt = div_ge ? {div_diff, div_shift[WIDTH-1:1], 1'b1}
                          : div_shift[2*WIDTH-1:0];
      end else begin
         acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc  <= '0;
         opnd <= '0;
      end else if (load) begin
         acc  <= {{WIDTH{1'b0}}, a_mag};
         opnd <= b_mag;
      end else if (step) begin
         acc  <= acc_nxt;
      end
   end

   assign result = acc;

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO: MTHI/MTLO in one cycle, MULT/DIV over WIDTH+1 cycles.
// Requests a pipeline stall while busy if EX needs the unit or HI/LO; flush aborts in-flight work.
module md_sequencer
   import md_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic [2:0]       md_func,
   input  logic             md_sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_read,
   input  logic             lo_read,
   input  logic             abort,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stall_req
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   md_state_e          state;
   md_state_e          state_nxt;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_nxt;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic [WIDTH-1:0]   hi_nxt;
   logic [WIDTH-1:0]   lo_nxt;
   logic               op_div;
   logic               neg_q;
   logic               neg_r;
   logic               b_zero;
   logic               load;
   logic               step;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [2*WIDTH-1:0] result;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   assign a_mag = (md_sign && a[WIDTH-1]) ? -a : a;
   assign b_mag = (md_sign && b[WIDTH-1]) ? -b : b;

   md_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .is_div (op_div),
      .a_mag  (a_mag),
      .b_mag  (b_mag),
      .result (result)
   );

   assign prod_fix = neg_q ? -result : result;
   assign quo      = result[WIDTH-1:0];
   assign rem      = result[2*WIDTH-1:WIDTH];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (issue && !abort) begin
               case (md_func)
                  MTHI: hi_nxt = a;
                  MTLO: lo_nxt = a;
                  MULT, DIV: begin
                     load      = 1'b1;
                     cnt_nxt   = '0;
                     state_nxt = CALC;
                  end
                  default: ;
               endcase
            end
         end
         CALC: begin
            step    = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) state_nxt = FIXUP;
         end
         FIXUP: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            if (op_div) begin
               // Restoring divide by zero already leaves |a| as remainder; only LO needs forcing.
               lo_nxt = b_zero ? '1 : (neg_q ? -quo : quo);
               hi_nxt = neg_r ? -rem : rem;
            end else begin
               {hi_nxt, lo_nxt} = prod_fix;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
      if (abort && state != IDLE) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         step      = 1'b0;
         hi_nxt    = hi_q;
         lo_nxt    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else if (load) begin
         op_div <= (md_func == DIV);
         neg_q  <= md_sign && (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r  <= md_sign && a[WIDTH-1];
         b_zero <= (b == '0);
      end
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign busy      = (state != IDLE);
   assign stall_req = busy && issue && (md_func_live(md_func) || hi_read || lo_read);

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: expected HI/LO queued at issue, compared when the unit goes idle.
module tb_md_sequencer;
   import md_pkg::*;

   localparam int W = MD_WIDTH;

   logic         clk = 1'b0;
   logic         rst;
   logic         issue;
   logic [2:0]   md_func;
   logic         md_sign;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         hi_read;
   logic         lo_read;
   logic         abort;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         busy;
   logic         stall_req;

   int n_checks = 0;
   int n_pass   = 0;
   logic [2*W-1:0] sb_q[$];

   always #5 clk = ~clk;

   md_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .issue     (issue),
      .md_func   (md_func),
      .md_sign   (md_sign),
      .a         (a),
      .b         (b),
      .hi_read   (hi_read),
      .lo_read   (lo_read),
      .abort     (abort),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .stall_req (stall_req)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      issue   = 1'b0;
      md_func = NOP;
      md_sign = 1'b0;
      hi_read = 1'b0;
      lo_read = 1'b0;
      abort   = 1'b0;
   endtask

   task automatic model(input logic [2:0] f, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, output logic [W-1:0] eh, output logic [W-1:0] el);
      longint      sp, sq, sr;
      logic [63:0] up;
      if (f == MULT) begin
         if (s) begin
            sp = longint'($signed(x)) * longint'($signed(y));
            eh = sp[63:32];
            el = sp[31:0];
         end else begin
            up = {32'b0, x} * {32'b0, y};
            eh = up[63:32];
            el = up[31:0];
         end
      end else if (y == '0) begin
         eh = x;
         el = '1;
      end else if (s) begin
         sq = longint'($signed(x)) / longint'($signed(y));
         sr = longint'($signed(x)) % longint'($signed(y));
         eh = sr[31:0];
         el = sq[31:0];
      end else begin
         eh = x % y;
         el = x / y;
      end
   endtask

   // Issue one MULT/DIV, scramble operands afterwards, then compare once the unit idles.
   task automatic run_md(input string tag, input logic [2:0] f, input logic s,
                         input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
      int n;
      logic [2*W-1:0] e;
      sb_q.push_back({eh, el});
      issue = 1'b1; md_func = f; md_sign = s; a = op_a; b = op_b;
      tick;
      idle_inputs;
      a = $urandom; b = $urandom;
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick;
      end
      check({tag, "_busy_cycles"}, n, MD_LATENCY);
      e = sb_q.pop_front();
      check({tag, "_hi"}, hi, e[2*W-1:W]);
      check({tag, "_lo"}, lo, e[W-1:0]);
   endtask

   task automatic run_move(input string tag, input logic [2:0] f, input logic [W-1:0] v,
                           input logic [W-1:0] eh, input logic [W-1:0] el);
      logic [2*W-1:0] e;
      sb_q.push_back({eh, el});
      issue = 1'b1; md_func = f; a = v;
      #1;
      check({tag, "_no_stall"}, stall_req, 1'b0);
      tick;
      idle_inputs;
      e = sb_q.pop_front();
      check({tag, "_hi"}, hi, e[2*W-1:W]);
      check({tag, "_lo"}, lo, e[W-1:0]);
      check({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]   f;
      logic         s;
      logic [W-1:0] x, y, eh, el;
      int           n;
      logic [2*W-1:0] e;

      idle_inputs;
      a = '0; b = '0;
      rst = 1'b0;
      repeat (2) tick;
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      check("reset_busy", busy, 0);
      check("reset_stall", stall_req, 0);
      rst = 1'b1;
      tick;

      run_move("mthi55", MTHI, 32'h55, 32'h55, 32'h0);

      run_md("multu_max", MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

      // MULT -3*5 followed immediately by MFLO, which must stall until the result lands.
      sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
      issue = 1'b1; md_func = MULT; md_sign = 1'b1; a = -32'sd3; b = 32'd5;
      tick;
      md_func = NOP; md_sign = 1'b0; lo_read = 1'b1; a = $urandom; b = $urandom;
      #1;
      n = 0;
      while (stall_req && n < 100) begin
         n++;
         @(posedge clk);
         #1;
      end
      check("mflo_stall_cycles", n, MD_LATENCY);
      check("mflo_busy_after", busy, 0);
      e = sb_q.pop_front();
      check("mult_neg_hi", hi, e[2*W-1:W]);
      check("mult_neg_lo", lo, e[W-1:0]);
      idle_inputs;
      tick;

      run_md("div_neg", DIV, 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu_zero", DIV, 1'b0, 32'h1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
      run_md("div_zero_s", DIV, 1'b1, -32'sd5, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      run_md("div_ovf", DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_md("divu_100_7", DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
      run_md("mult_m1m1", MULT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);

      for (int i = 0; i < 8; i++) begin
         f = i[0] ? DIV : MULT;
         s = i[1];
         x = $urandom;
         y = (i[2]) ? W'($urandom_range(1, 1000)) : W'($urandom);
         model(f, s, x, y, eh, el);
         run_md($sformatf("rand%0d", i), f, s, x, y, eh, el);
      end

      // Abort mid-MULT: preloaded HI/LO survive, and issue while busy is ignored.
      run_move("mthi_a", MTHI, 32'hA, 32'hA, lo);
      run_move("mtlo_b", MTLO, 32'hB, 32'hA, 32'hB);
      issue = 1'b1; md_func = MULT; md_sign = 1'b0; a = 32'd7; b = 32'd9;
      tick;
      idle_inputs;
      repeat (3) tick;
      issue = 1'b1; md_func = MTHI; a = 32'h77;
      #1;
      check("busy_issue_stall", stall_req, 1'b1);
      tick;
      md_func = NOP;
      #1;
      check("independent_no_stall", stall_req, 1'b0);
      idle_inputs;
      repeat (4) tick;
      check("pre_abort_busy", busy, 1'b1);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_hi", hi, 32'hA);
      check("abort_lo", lo, 32'hB);
      repeat (40) tick;
      check("abort_late_hi", hi, 32'hA);
      check("abort_late_lo", lo, 32'hB);

      // Abort in IDLE beats a simultaneous issue.
      issue = 1'b1; md_func = MTHI; a = 32'h99; abort = 1'b1;
      tick;
      idle_inputs;
      check("idle_abort_hi", hi, 32'hA);
      issue = 1'b1; md_func = DIV; a = 32'h99; b = 32'h3; abort = 1'b1;
      tick;
      idle_inputs;
      check("idle_abort_busy", busy, 1'b0);

      // Reset in the middle of a DIV clears everything immediately.
      issue = 1'b1; md_func = DIV; md_sign = 1'b0; a = 32'd100; b = 32'd3;
      tick;
      idle_inputs;
      repeat (5) tick;
      check("pre_rst_busy", busy, 1'b1);
      rst = 1'b0;
      #1;
      check("rst_mid_hi", hi, 0);
      check("rst_mid_lo", lo, 0);
      check("rst_mid_busy", busy, 0);
      tick;
      rst = 1'b1;
      tick;
      run_md("post_rst_multu", MULT, 1'b0, 32'd1000, 32'd3000, 32'h0, 32'd3000000);

      check("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
